// File: rtl/ac_motor_gate_monitor_pkg.sv
// Shared definitions for the gate monitor and the dead-time generators.
package ac_motor_gate_monitor_pkg;

  localparam int unsigned DELAY_W_DEF = 11;
  localparam int unsigned N_PHASE     = 3;

  // Per-phase gate FSM encoding
  typedef enum logic [1:0] {
    PH_LOW   = 2'd0,
    PH_HIGH  = 2'd1,
    PH_DEAD  = 2'd2,
    PH_FAULT = 2'd3
  } phase_state_e;

endpackage

// File: rtl/ac_motor_gate_phase_check.sv
// One phase: conduction FSM, dead-time gap counter and sticky fault flags.
module ac_motor_gate_phase_check
  import ac_motor_gate_monitor_pkg::*;
#(
  parameter int unsigned DELAY_W = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [DELAY_W-1:0] delay,
  input  logic               clear_fault,
  input  logic               gate_h,
  input  logic               gate_l,
  output phase_state_e       state_c,
  output logic               shoot_err_c,
  output logic               dead_err_c,
  output logic               shoot_err,
  output logic               dead_err
);

  localparam logic [DELAY_W-1:0] CNT_MAX = '1;

  phase_state_e       state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic               shoot_q, shoot_d;
  logic               dead_q, dead_d;
  logic               shoot_evt, dead_evt;

  // Next-state, gap counter and flag update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shoot_evt = 1'b0;
    dead_evt  = 1'b0;
    if (!enable) begin
      state_d = PH_DEAD;
      cnt_d   = CNT_MAX;
    end else if (gate_h && gate_l) begin
      // Shoot-through outranks any dead-time judgement
      state_d   = PH_FAULT;
      shoot_evt = 1'b1;
    end else begin
      case (state_q)
        PH_LOW: begin
          if (!gate_h && !gate_l) begin
            state_d = PH_DEAD;
            cnt_d   = DELAY_W'(1);
          end else if (gate_h) begin
            state_d  = PH_HIGH;
            dead_evt = (delay != '0);
          end
        end
        PH_HIGH: begin
          if (!gate_h && !gate_l) begin
            state_d = PH_DEAD;
            cnt_d   = DELAY_W'(1);
          end else if (gate_l) begin
            state_d  = PH_LOW;
            dead_evt = (delay != '0);
          end
        end
        PH_DEAD: begin
          if (!gate_h && !gate_l) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + DELAY_W'(1);
          end else begin
            state_d  = gate_h ? PH_HIGH : PH_LOW;
            dead_evt = (cnt_q < delay);
          end
        end
        PH_FAULT: begin
          if (clear_fault) begin
            state_d = PH_DEAD;
            cnt_d   = CNT_MAX;
          end
        end
      endcase
    end
    // A new event on the clearing edge keeps the flag set
    shoot_d = (shoot_q & ~clear_fault) | shoot_evt;
    dead_d  = (dead_q  & ~clear_fault) | dead_evt;
  end

  // State and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PH_DEAD;
      cnt_q   <= CNT_MAX;
      shoot_q <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shoot_q <= shoot_d;
      dead_q  <= dead_d;
    end
  end

  assign state_c     = state_d;
  assign shoot_err_c = shoot_d;
  assign dead_err_c  = dead_d;
  assign shoot_err   = shoot_q;
  assign dead_err    = dead_q;

endmodule

// File: rtl/ac_motor_gate_monitor.sv
// Receive-side gate drive checker: three phase checkers plus switch-state decode.
module ac_motor_gate_monitor
  import ac_motor_gate_monitor_pkg::*;
#(
  parameter int unsigned DELAY_W = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [DELAY_W-1:0] delay,
  input  logic               clear_fault,
  input  logic [2:0]         gate_high,
  input  logic [2:0]         gate_low,
  output logic [2:0]         switch_state,
  output logic               state_valid,
  output logic               vector_change,
  output logic [2:0]         shoot_err,
  output logic [2:0]         dead_err,
  output logic               fault
);

  phase_state_e phase_st_c [N_PHASE];
  logic [2:0]   shoot_c, dead_c;

  logic [2:0] switch_q, switch_d;
  logic       valid_q, valid_d;
  logic       vchg_q, vchg_d;
  logic       fault_q, fault_d;
  logic       have_ref_q, have_ref_d;
  logic       all_cond, any_fault;
  logic [2:0] pattern;

  for (genvar g = 0; g < int'(N_PHASE); g++) begin : g_phase
    ac_motor_gate_phase_check #(.DELAY_W(DELAY_W)) u_phase (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .delay       (delay),
      .clear_fault (clear_fault),
      .gate_h      (gate_high[g]),
      .gate_l      (gate_low[g]),
      .state_c     (phase_st_c[g]),
      .shoot_err_c (shoot_c[g]),
      .dead_err_c  (dead_c[g]),
      .shoot_err   (shoot_err[g]),
      .dead_err    (dead_err[g])
    );
  end

  // Decode next phase states into switch pattern, validity and change strobe
  always_comb begin
    all_cond  = 1'b1;
    any_fault = 1'b0;
    pattern   = '0;
    for (int i = 0; i < int'(N_PHASE); i++) begin
      all_cond   = all_cond & ((phase_st_c[i] == PH_HIGH) || (phase_st_c[i] == PH_LOW));
      any_fault  = any_fault | (phase_st_c[i] == PH_FAULT);
      pattern[i] = (phase_st_c[i] == PH_HIGH);
    end
    valid_d    = enable & all_cond;
    switch_d   = valid_d ? pattern : switch_q;
    // No reference pattern after reset, disable or a shoot-through fault
    vchg_d     = valid_d & (~have_ref_q | (pattern != switch_q));
    have_ref_d = enable & ~any_fault & (have_ref_q | valid_d);
    fault_d    = (|shoot_c) | (|dead_c);
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      switch_q   <= '0;
      valid_q    <= 1'b0;
      vchg_q     <= 1'b0;
      fault_q    <= 1'b0;
      have_ref_q <= 1'b0;
    end else begin
      switch_q   <= switch_d;
      valid_q    <= valid_d;
      vchg_q     <= vchg_d;
      fault_q    <= fault_d;
      have_ref_q <= have_ref_d;
    end
  end

  assign switch_state  = switch_q;
  assign state_valid   = valid_q;
  assign vector_change = vchg_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_ac_motor_gate_monitor.sv
// Directed bench for ac_motor_gate_monitor.
module tb_ac_motor_gate_monitor;
  import ac_motor_gate_monitor_pkg::*;

  localparam int unsigned DW = DELAY_W_DEF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [DW-1:0] delay;
  logic          clear_fault;
  logic [2:0]    gate_high, gate_low;
  logic [2:0]    switch_state;
  logic          state_valid, vector_change;
  logic [2:0]    shoot_err, dead_err;
  logic          fault;

  int n_cmp = 0;
  int n_bad = 0;

  ac_motor_gate_monitor #(.DELAY_W(DW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .delay         (delay),
    .clear_fault   (clear_fault),
    .gate_high     (gate_high),
    .gate_low      (gate_low),
    .switch_state  (switch_state),
    .state_valid   (state_valid),
    .vector_change (vector_change),
    .shoot_err     (shoot_err),
    .dead_err      (dead_err),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sw"},    32'(switch_state),  32'h0);
    check({tag, ".sv"},    32'(state_valid),   32'h0);
    check({tag, ".vc"},    32'(vector_change), 32'h0);
    check({tag, ".shoot"}, 32'(shoot_err),     32'h0);
    check({tag, ".dead"},  32'(dead_err),      32'h0);
    check({tag, ".fault"}, 32'(fault),         32'h0);
  endtask

  logic [2:0] seq [6];
  logic [2:0] diff;

  initial begin
    seq = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    reset_n = 1'b0; enable = 1'b0; delay = DW'(500); clear_fault = 1'b0;
    gate_high = 3'b000; gate_low = 3'b000;
    tick(2);
    reset_n = 1'b1;
    check_all_zero("reset");

    // First valid pattern: all low
    enable = 1'b1; gate_low = 3'b111;
    tick(1);
    check("first.sv", 32'(state_valid), 32'h1);
    check("first.sw", 32'(switch_state), 32'h0);
    check("first.vc", 32'(vector_change), 32'h1);
    check("first.dead", 32'(dead_err), 32'h0);
    tick(1);
    check("hold.vc", 32'(vector_change), 32'h0);

    // Clean 500-cycle gap on phase 1
    gate_low = 3'b110;
    tick(1);
    check("gap.sv", 32'(state_valid), 32'h0);
    check("gap.sw", 32'(switch_state), 32'h0);
    tick(499);
    gate_high = 3'b001;
    tick(1);
    check("g500.sv", 32'(state_valid), 32'h1);
    check("g500.sw", 32'(switch_state), 32'h1);
    check("g500.vc", 32'(vector_change), 32'h1);
    check("g500.dead", 32'(dead_err), 32'h0);
    check("g500.fault", 32'(fault), 32'h0);

    // 499-cycle gap: violation
    gate_high = 3'b000;
    tick(499);
    gate_low = 3'b111;
    tick(1);
    check("g499.dead", 32'(dead_err), 32'h1);
    check("g499.fault", 32'(fault), 32'h1);
    check("g499.sw", 32'(switch_state), 32'h0);
    check("g499.vc", 32'(vector_change), 32'h1);
    tick(3);
    check("g499.sticky", 32'(dead_err), 32'h1);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    check("clr1.dead", 32'(dead_err), 32'h0);
    check("clr1.fault", 32'(fault), 32'h0);

    // Shoot-through on phase 2
    gate_high = 3'b010;
    tick(1);
    check("st.shoot", 32'(shoot_err), 32'h2);
    check("st.sv", 32'(state_valid), 32'h0);
    check("st.fault", 32'(fault), 32'h1);
    gate_high = 3'b000;
    tick(3);
    check("st.hold.sv", 32'(state_valid), 32'h0);
    check("st.hold.shoot", 32'(shoot_err), 32'h2);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    check("st.clr.shoot", 32'(shoot_err), 32'h0);
    check("st.clr.sv", 32'(state_valid), 32'h0);
    tick(1);
    check("st.rec.sv", 32'(state_valid), 32'h1);
    check("st.rec.vc", 32'(vector_change), 32'h1);
    check("st.rec.dead", 32'(dead_err), 32'h0);

    // Direct transitions, delay 0 then 1
    delay = DW'(0);
    gate_high = 3'b001; gate_low = 3'b110;
    tick(1);
    check("d0.dead", 32'(dead_err), 32'h0);
    check("d0.sw", 32'(switch_state), 32'h1);
    delay = DW'(1);
    gate_high = 3'b000; gate_low = 3'b111;
    tick(1);
    check("d1.dead", 32'(dead_err), 32'h1);
    check("d1.sw", 32'(switch_state), 32'h0);

    // Clear coincident with a new violation: event wins
    clear_fault = 1'b1;
    gate_high = 3'b001; gate_low = 3'b110;
    tick(1);
    check("clrevt.dead", 32'(dead_err), 32'h1);
    tick(1);
    clear_fault = 1'b0;
    check("clronly.dead", 32'(dead_err), 32'h0);
    check("clronly.fault", 32'(fault), 32'h0);

    // Disable: outputs idle, no flags, switch_state held
    enable = 1'b0;
    tick(1);
    check("dis.sv", 32'(state_valid), 32'h0);
    check("dis.vc", 32'(vector_change), 32'h0);
    check("dis.sw", 32'(switch_state), 32'h1);
    gate_high = 3'b101; gate_low = 3'b110;
    tick(1);
    check("dis.shoot", 32'(shoot_err), 32'h0);
    gate_high = 3'b001;
    enable = 1'b1;
    tick(1);
    check("en.sv", 32'(state_valid), 32'h1);
    check("en.vc", 32'(vector_change), 32'h1);
    check("en.dead", 32'(dead_err), 32'h0);

    // Six-step rotation with exact-delay gaps
    delay = DW'(3);
    for (int k = 0; k < 6; k++) begin
      diff = seq[k] ^ gate_high;
      gate_high = gate_high & ~diff;
      gate_low  = gate_low & ~diff;
      tick(3);
      gate_high = seq[k];
      gate_low  = ~seq[k];
      tick(1);
      check($sformatf("rot%0d.sw", k), 32'(switch_state), 32'(seq[k]));
      check($sformatf("rot%0d.vc", k), 32'(vector_change), 32'h1);
      check($sformatf("rot%0d.fault", k), 32'(fault), 32'h0);
    end

    // Asynchronous reset mid-operation
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    #2;
    reset_n = 1'b1;
    tick(1);
    check("post.sv", 32'(state_valid), 32'h1);
    check("post.vc", 32'(vector_change), 32'h1);
    check("post.sw", 32'(switch_state), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
